decode_execute_pipe: RTL and testbench
======================================

# decode_execute_pipe

Parametrised, pipelined successor to the combinational 4-bit decode-and-execute unit. It pairs an internal register file of `2**ADDR_W` entries with a two-stage read/execute pipeline and a valid/ready instruction handshake. It implements the same eight-opcode ALU at any width, plus an immediate-load path and carry/zero flags. It sits between the instruction source (switch UI or sequencer) and the seven-segment display driver, which consumes `out_data`.

## Interface
- `WIDTH`, 4: datapath width in bits; legal range is ≥ 4.
- `ADDR_W`, 2: register address width; the register count is `2**ADDR_W`.

- `clk`  in  1  the single clock, rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  unit accepts the instruction this cycle.
- `op`  in  3  opcode; ignored when `imm_en=1`.
- `imm_en`  in  1  1 = load `imm` into `rd_addr`.
- `imm`  in  WIDTH  immediate value.
- `rs_addr`, `rt_addr`, `rd_addr`  in  ADDR_W each  source and destination registers.
- `out_valid`  out  1  one-cycle pulse: result written.
- `out_rd_addr`  out  ADDR_W  destination of the reported result.
- `out_data`  out  WIDTH  result.
- `out_carry`, `out_zero`  out  1 each  flags for the result.

## Operation
- Accept condition: `in_valid & in_ready` at a rising edge. Stage 1 then latches the op, `rd_addr`, and the rs/rt operand values.
- Stage 2 executes combinationally and, at the next edge:
  - writes `regfile[rd]`;
  - registers `out_*`;
  - pulses `out_valid`.
- Opcodes (arithmetic is mod `2**WIDTH`):
  - 000 ADD: `rs+rt`; carry = carry-out.
  - 001 SUB: `rs-rt`; carry = 1 iff `rs ≥ rt` (unsigned).
  - 010 AND and 011 OR: carry = 0.
  - 100 ROL: `rs` rotated left by 1; carry = `rs[W-1]`.
  - 101 ASR: `rt` shifted arithmetically right by 1; carry = `rt[0]`.
  - 110 EQ: bits `[W-1:1]` all 1; bit 0 = (`rs==rt`); carry = 0.
  - 111 GT: bit `W-1` = 1, bit 1 = 1, all other upper bits 0; bit 0 = (`rs>rt`, unsigned); carry = 0.
  - Immediate load: result = `imm`; carry = 0.
- `out_zero` = (result == 0) for every op.
- `rs_addr == rt_addr` is legal. Any register may be the destination; there is no hardwired zero register.
- Hazard: an instruction in stage 1 writes its destination only at the edge on which the next instruction latches its operands.
  - When a newly presented `rs_addr` or `rt_addr` equals the stage-1 `rd`, the regfile value is stale.
  - That case is handled per `## Configuration`.
  - There is no other hazard distance.
- No output backpressure: `out_valid` is a pulse that the consumer must take.
- Reset:
  - All registers and the pipeline valid bit clear to 0.
  - `out_valid`, `out_data`, `out_rd_addr`, `out_carry` and `out_zero` are 0.
  - `in_ready` is 0 while `rst=1`.
  - An in-flight instruction is dropped: no regfile write and no `out_valid`.

## Timing
- Latency: accept at edge E0 → regfile write and `out_valid` at edge E0+1. `out_valid` is high during the cycle after E0+1.
- Throughput: 1 instruction per cycle when there is no stall.
- `in_ready` is 1 in the first cycle after `rst` drops.
- `out_*` hold their last value between pulses. Only `out_valid` returns to 0.
- A regfile write and a read of the same address in the same cycle return the old value unless forwarding applies.

## Configuration
- Macro: `DECODE_EXECUTE_PIPE_FORWARD_EN`.
- Defined:
  - On an address match with the valid stage-1 `rd`, the operand mux selects the stage-2 combinational result instead of the regfile.
  - `in_ready` is constantly 1 outside reset.
- Undefined:
  - On such a match, `in_ready` drops for exactly one cycle and no instruction is accepted.
  - The instruction is accepted on the following cycle, with correct operands.
- Results are bit-identical in both builds; only the acceptance timing differs.

## Test plan
Bench configuration: `WIDTH=4`, `ADDR_W=2`.
- Reset, then load `r1=7` and `r2=3`, then ADD `r3=r1+r2` → `out_data=4'hA`, `carry=0`, `zero=0`, `out_rd_addr=3`, with `out_valid` at E0+1.
- SUB `r1-r2` (7,3) → `4'h4`, `carry=1`. SUB `r2-r1` → `4'hC`, `carry=0`. SUB `r1-r1` → `4'h0`, `zero=1`.
- Load `r0=5`, then immediately ADD `r1=r0+r0` → `4'hA`.
  - With the macro defined: `in_ready` stays 1.
  - Without the macro: `in_ready` is 0 for one cycle and the result arrives one cycle later.
- EQ with 9,9 → `4'hF`. GT with 9,3 → `4'hB`. GT with 3,9 → `4'hA`.
- ROL of `4'b1001` → `4'b0011`, `carry=1`. ASR of `4'b1000` → `4'b1100`, `carry=0`.
- Accept ADD into `r3`, then assert `rst` on the next cycle → no `out_valid`; after reset, reading `r3` returns 0.

Source files
------------

// File: rtl/decode_execute_pipe.sv
// Two-stage register-file decode/execute pipe with valid/ready instruction input.
// Optional operand forwarding: define DECODE_EXECUTE_PIPE_FORWARD_EN (default: one-cycle stall).
module decode_execute_pipe #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic              imm_en,
    input  logic [WIDTH-1:0]  imm,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_rd_addr,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_carry,
    output logic              out_zero
);
    localparam int NREG = 2**ADDR_W;

    typedef struct packed {
        logic              imm_en;
        logic [2:0]        op;
        logic [WIDTH-1:0]  imm;
        logic [ADDR_W-1:0] rd;
        logic [WIDTH-1:0]  a;
        logic [WIDTH-1:0]  b;
    } s1_t;

    logic [NREG-1:0][WIDTH-1:0] regfile;
    logic [1:0]                 vld_pipe;  // [0]: stage 1 occupied, [1]: result reported
    s1_t                        s1;
    logic [WIDTH-1:0]           res, opa, opb;
    logic [WIDTH:0]             sum;
    logic                       res_c, hit_s, hit_t, accept;

    assign hit_s  = vld_pipe[0] && (rs_addr == s1.rd);
    assign hit_t  = vld_pipe[0] && (rt_addr == s1.rd);
    assign accept = in_valid && in_ready;

`ifdef DECODE_EXECUTE_PIPE_FORWARD_EN
    assign in_ready = !rst;
    assign opa      = hit_s ? res : regfile[rs_addr];
    assign opb      = hit_t ? res : regfile[rt_addr];
`else
    // The stage-1 write lands on the stall edge, so the retry reads fresh data.
    assign in_ready = !rst && !(in_valid && (hit_s || hit_t));
    assign opa      = regfile[rs_addr];
    assign opb      = regfile[rt_addr];
`endif

    always_comb begin
        res   = '0;
        res_c = 1'b0;
        sum   = {1'b0, s1.a} + {1'b0, s1.b};
        if (s1.imm_en) begin
            res = s1.imm;
        end else begin
            case (s1.op)
                3'd0: begin res = sum[WIDTH-1:0]; res_c = sum[WIDTH]; end
                3'd1: begin res = s1.a - s1.b; res_c = (s1.a >= s1.b); end
                3'd2: res = s1.a & s1.b;
                3'd3: res = s1.a | s1.b;
                3'd4: begin res = {s1.a[WIDTH-2:0], s1.a[WIDTH-1]}; res_c = s1.a[WIDTH-1]; end
                3'd5: begin res = {s1.b[WIDTH-1], s1.b[WIDTH-1:1]}; res_c = s1.b[0]; end
                3'd6: res = {{(WIDTH-1){1'b1}}, (s1.a == s1.b)};
                default: begin
                    res[WIDTH-1] = 1'b1;
                    res[1]       = 1'b1;
                    res[0]       = (s1.a > s1.b);
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe    <= '0;
            s1          <= '0;
            regfile     <= '0;
            out_rd_addr <= '0;
            out_data    <= '0;
            out_carry   <= 1'b0;
            out_zero    <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[0], accept};
            if (accept)
                s1 <= {imm_en, op, imm, rd_addr, opa, opb};
            if (vld_pipe[0]) begin
                regfile[s1.rd] <= res;
                out_rd_addr    <= s1.rd;
                out_data       <= res;
                out_carry      <= res_c;
                out_zero       <= (res == '0);
            end
        end
    end

    assign out_valid = vld_pipe[1];
endmodule

// File: tb/tb_decode_execute_pipe.sv
// Bench for decode_execute_pipe: directed vector table, reset corner cases,
// then random instructions against an architectural (sequential) model.
module tb_decode_execute_pipe;
`ifdef DECODE_EXECUTE_PIPE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, imm_en = 1'b0;
    logic [2:0] op = '0;
    logic [3:0] imm = '0, out_data;
    logic [1:0] rs_addr = '0, rt_addr = '0, rd_addr = '0, out_rd_addr;
    logic       out_valid, out_carry, out_zero;

    decode_execute_pipe #(.WIDTH(4), .ADDR_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .imm_en(imm_en), .imm(imm),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .out_valid(out_valid), .out_rd_addr(out_rd_addr), .out_data(out_data),
        .out_carry(out_carry), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit ie; int op; int imm; int rs; int rt; int rd;
        int ed; bit ec; bit ez;
    } vec_t;

    typedef struct { int rd; int d; bit c; bit z; int acc; } exp_t;

    int   nvec = 0, nerr = 0, cyc = 0, last_acc = -10, last_rd = 0;
    int   mregs[4];
    exp_t q[$];
    vec_t tbl[19];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input bit ie, input int o, im, s, t, d, ed, input bit ec, ez);
        vec_t v;
        v.ie = ie; v.op = o; v.imm = im; v.rs = s; v.rt = t; v.rd = d;
        v.ed = ed; v.ec = ec; v.ez = ez;
        return v;
    endfunction

    function automatic void ref_alu(input bit ie, input int o, im, a, b,
                                    output int d, output bit c);
        c = 1'b0;
        if (ie) d = im;
        else case (o)
            0: begin d = (a + b) % 16; c = (a + b) > 15; end
            1: begin d = (a - b + 16) % 16; c = (a >= b); end
            2: d = a & b;
            3: d = a | b;
            4: begin d = (a * 2) % 16 + a / 8; c = (a >= 8); end
            5: begin d = b / 2 + ((b >= 8) ? 8 : 0); c = (b % 2) == 1; end
            6: d = (a == b) ? 15 : 14;
            default: d = (a > b) ? 11 : 10;
        endcase
    endfunction

    // Every out_valid pulse must match the oldest outstanding instruction.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (q.size() == 0) chk("spurious out_valid", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("out_rd_addr", 32'(out_rd_addr), e.rd);
                chk("out_data", 32'(out_data), e.d);
                chk("out_carry", 32'(out_carry), 32'(e.c));
                chk("out_zero", 32'(out_zero), 32'(e.z));
                chk("latency", cyc, e.acc + 1);
            end
        end
    end

    task automatic issue(input vec_t v);
        int st;
        bit hz;
        exp_t e;
        in_valid = 1'b1; imm_en = v.ie; op = 3'(v.op); imm = 4'(v.imm);
        rs_addr = 2'(v.rs); rt_addr = 2'(v.rt); rd_addr = 2'(v.rd);
        st = 0;
        @(negedge clk);
        hz = !FWD && (last_acc == cyc) && (v.rs == last_rd || v.rt == last_rd);
        while (in_ready !== 1'b1 && st < 5) begin st++; @(negedge clk); end
        if (in_ready !== 1'b1) begin
            chk("accept timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        chk("stall cycles", st, hz ? 1 : 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        last_acc = cyc; last_rd = v.rd;
        e.rd = v.rd; e.d = v.ed; e.c = v.ec; e.z = v.ez; e.acc = cyc;
        q.push_back(e);
        mregs[v.rd] = v.ed;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("in_ready in reset", 32'(in_ready), 0);
        chk("out_valid in reset", 32'(out_valid), 0);
        chk("out_data in reset", 32'(out_data), 0);
        chk("out_rd_addr in reset", 32'(out_rd_addr), 0);
        chk("out_carry/zero in reset", 32'({out_carry, out_zero}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        foreach (mregs[i]) mregs[i] = 0;
        last_acc = -10;
        @(negedge clk);
        chk("in_ready after reset", 32'(in_ready), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t v;
        int d;
        bit c;
        tbl[0]  = mk(1, 0, 7, 0, 0, 1,  7, 0, 0);
        tbl[1]  = mk(1, 0, 3, 0, 0, 2,  3, 0, 0);
        tbl[2]  = mk(0, 0, 0, 1, 2, 3, 10, 0, 0);  // ADD r3=r1+r2
        tbl[3]  = mk(0, 1, 0, 1, 2, 0,  4, 1, 0);
        tbl[4]  = mk(0, 1, 0, 2, 1, 0, 12, 0, 0);
        tbl[5]  = mk(0, 1, 0, 1, 1, 0,  0, 1, 1);
        tbl[6]  = mk(1, 0, 5, 3, 3, 0,  5, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 1, 10, 0, 0);  // back-to-back r0 dependency
        tbl[8]  = mk(1, 0, 9, 3, 3, 2,  9, 0, 0);
        tbl[9]  = mk(1, 0, 9, 0, 0, 3,  9, 0, 0);
        tbl[10] = mk(0, 6, 0, 2, 3, 0, 15, 0, 0);
        tbl[11] = mk(1, 0, 3, 2, 2, 1,  3, 0, 0);
        tbl[12] = mk(0, 7, 0, 2, 1, 0, 11, 0, 0);
        tbl[13] = mk(0, 7, 0, 1, 2, 0, 10, 0, 0);
        tbl[14] = mk(0, 4, 0, 2, 2, 0,  3, 1, 0);
        tbl[15] = mk(1, 0, 8, 3, 3, 1,  8, 0, 0);
        tbl[16] = mk(0, 5, 0, 1, 1, 0, 12, 0, 0);
        tbl[17] = mk(0, 2, 0, 1, 2, 0,  8, 0, 0);
        tbl[18] = mk(0, 3, 0, 1, 3, 0,  9, 0, 0);

        do_reset();
        for (int i = 0; i < 19; i++) issue(tbl[i]);
        repeat (3) @(posedge clk);
        #1;
        chk("table results drained", q.size(), 0);

        // In-flight instruction killed by reset: no pulse, no write.
        issue(mk(0, 0, 0, 1, 2, 3, 1, 1, 0));
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        chk("out_valid after kill", 32'(out_valid), 0);
        do_reset();
        issue(mk(0, 0, 0, 3, 3, 0, 0, 0, 1));  // r3 must read back as 0

        for (int n = 0; n < 300; n++) begin
            v.ie = ($urandom_range(0, 3) == 0);
            v.op = $urandom_range(0, 7);
            v.imm = $urandom_range(0, 15);
            v.rs = $urandom_range(0, 3);
            v.rt = $urandom_range(0, 3);
            v.rd = $urandom_range(0, 3);
            ref_alu(v.ie, v.op, v.imm, mregs[v.rs], mregs[v.rt], d, c);
            v.ed = d; v.ec = c; v.ez = (d == 0);
            issue(v);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk); #1;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        chk("random results drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
